prpg_lfsr_n: RTL

PRPG_LFSR_N -- requirements
Module: prpg_lfsr_n

---
 rtl/prpg_lfsr_n.sv | 114 +++++++++++
 1 files changed

// File: rtl/prpg_lfsr_n.sv
// Loadable Fibonacci LFSR pattern generator with counted, free-running and held runs.
// Latency: a pattern shows on PrpgOut the cycle after Start; no backpressure (Hold pauses, Stop aborts).
module prpg_lfsr_n #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             ResetB,
  input  logic             PrpgUpld,
  input  logic [WIDTH-1:0] PrpgSeed,
  input  logic [WIDTH-1:0] PrpgPoly,
  input  logic             PrpgStart,
  input  logic [CNT_W-1:0] PrpgLen,
  input  logic             PrpgHold,
  input  logic             PrpgStop,
  output logic [WIDTH-1:0] PrpgOut,
  output logic             PrpgValid,
  output logic             PrpgBusy,
  output logic             PrpgDone,
  output logic             PrpgLockup
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT            state;
  stateT            stateNext;
  logic [WIDTH-1:0] prpgReg;
  logic [WIDTH-1:0] polyReg;
  logic [WIDTH-1:0] prpgNext;
  logic [CNT_W-1:0] cnt;
  logic             freeRun;
  logic             lockupReg;
  logic             feedback;
  logic             advance;
  logic             lastPattern;
  logic             idleUpld;
  logic             idleStart;

  assign feedback    = ^(prpgReg & polyReg);
  assign prpgNext    = {prpgReg[WIDTH-2:0], feedback};
  assign idleUpld    = (state == IDLE) && PrpgUpld;
  assign idleStart   = (state == IDLE) && PrpgStart;
  // Stop outranks Hold; either one suppresses the pattern for this cycle.
  assign advance     = (state == RUN) && !PrpgStop && !PrpgHold;
  assign lastPattern = advance && !freeRun && (cnt == CNT_W'(1));

  always_ff @(posedge Clk) begin
    if (!ResetB) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (PrpgStart) stateNext = RUN;
      end
      RUN: begin
        if (PrpgStop)         stateNext = IDLE;
        else if (lastPattern) stateNext = DONE;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Datapath; the register is kept across IDLE so a bare Start continues the sequence.
  always_ff @(posedge Clk) begin
    if (!ResetB) begin
      prpgReg   <= '0;
      polyReg   <= '0;
      cnt       <= '0;
      freeRun   <= 1'b0;
      lockupReg <= 1'b0;
    end else begin
      if (idleUpld) begin
        prpgReg <= PrpgSeed;
        polyReg <= PrpgPoly;
      end else if (advance) begin
        prpgReg <= prpgNext;
      end

      if (idleStart) begin
        cnt     <= PrpgLen;
        freeRun <= (PrpgLen == '0);
      end else if (advance && !freeRun) begin
        cnt <= cnt - CNT_W'(1);
      end

      if (idleUpld) begin
        lockupReg <= 1'b0;
      end else if ((state == RUN) && (prpgReg == '0)) begin
        lockupReg <= 1'b1;
      end
    end
  end

  always_comb begin
    PrpgValid  = advance;
    PrpgOut    = advance ? prpgReg : '0;
    PrpgBusy   = (state == RUN);
    PrpgDone   = (state == DONE);
    // Combinational term makes the flag visible in the very first stuck RUN cycle.
    PrpgLockup = lockupReg || ((state == RUN) && (prpgReg == '0));
  end

endmodule
